gpi_debounce: RTL and testbench
===============================

# gpi_debounce

Synchronises and debounces the raw board switch and button inputs before they reach the demo system's general-purpose input port. Sits between the FPGA pins (SW, BTN) and `gp_i` of `ibex_demo_system` in the board top level, in the `clk_sys` domain. Each bit passes through a two-flop synchroniser and a per-channel stability counter paced by a shared prescaler tick. The block produces clean levels plus optional one-cycle rise/fall pulses.

## Interface
- `Width`, 8: number of input channels.
- `TickCycles`, 50000: clk cycles per sample tick (1 ms at 50 MHz); legal range ≥1.
- `StableTicks`, 10: consecutive mismatching ticks needed to accept a new level; legal range 1..255.
- `clk_sys_i` in 1: system clock.
- `rst_sys_ni` in 1: asynchronous, active-low reset.
- `gp_raw_i` in Width: asynchronous raw pin levels.
- `gp_o` out Width: debounced level; reset 0.
- `rise_o` out Width: one-cycle pulse when `gp_o` bit goes 0→1; reset 0.
- `fall_o` out Width: one-cycle pulse when `gp_o` bit goes 1→0; reset 0.
- `tick_o` out 1: prescaler tick, for observation; reset 0.

## Operation
- Synchroniser: two flops per bit; reset value 0; output `sync[i]`.
- Prescaler: counter `pre` counts 0..TickCycles-1 and wraps; free-running from reset release. `tick` is registered and high for exactly one cycle when `pre` wraps. TickCycles=1 drives `tick` high every cycle.
- Per channel: `cnt[i]` has width `$clog2(StableTicks+1)`, with a minimum of 1.
  - Any cycle with `sync[i]==gp_o[i]` clears `cnt[i]`, whether or not `tick` is high. A glitch shorter than one tick therefore restarts qualification.
  - `sync[i]!=gp_o[i]` and `tick` and `cnt[i]<StableTicks-1` increments `cnt[i]`.
  - `sync[i]!=gp_o[i]` and `tick` and `cnt[i]==StableTicks-1` sets `gp_o[i]` to `sync[i]` on the next edge and clears `cnt[i]`.
  - Otherwise `cnt[i]` holds.
- Edges: `rise_o[i]` and `fall_o[i]` are registered and assert in the same cycle that `gp_o[i]` takes its new value, for exactly one cycle.
- Channels are fully independent. Any combination may flip in the same cycle.
- Reset asserted mid-qualification: all counters, `gp_o` and pulses clear immediately. No edge pulse is generated for the reset-induced change.
- A pin that is 1 at reset release reports `rise_o` once it has qualified.
- Elaboration error if TickCycles<1, StableTicks<1 or StableTicks>255.

## Timing
- Sync latency: 2 cycles from pin to `sync`.
- Qualification: a steady level change is reflected on `gp_o` between (StableTicks-1)·TickCycles+3 and StableTicks·TickCycles+2 cycles after the pin edge, depending on prescaler phase.
- Bounce of period shorter than one tick never changes `gp_o`.
- No combinational path from any input to any output.

## Configuration
- `GPI_DEBOUNCE_EDGE_EN` defined: edge detection registers are built and `rise_o`/`fall_o` behave as above.
- `GPI_DEBOUNCE_EDGE_EN` undefined: no edge logic is built; `rise_o` and `fall_o` are tied to 0. `gp_o` behaviour is unchanged.

## Structure
- Shared package `gpi_debounce_pkg`:
  - `DefaultTickCycles`, `DefaultStableTicks`, `MaxStableTicks` constants.
  - `deb_cnt_t` typedef for the per-channel counter, sized from `MaxStableTicks`.
- Sub-module `gpi_debounce_chan`: one channel (synchroniser, counter, level, edge), instantiated Width times in a generate loop.
- Prescaler lives in the top of the block and is shared by all channels.

## Test plan
All scenarios use TickCycles=4, StableTicks=3.
- Reset and idle: hold reset with all inputs 0, release, run 100 cycles → `gp_o`, `rise_o`, `fall_o` all 0; `tick_o` pulses every 4 cycles.
- Clean press: bit 0 steps 0→1 and holds → `gp_o[0]`=1 within 11–14 cycles of the step; `rise_o[0]` high exactly 1 cycle, in the same cycle `gp_o[0]` changes.
- Bounce rejection: bit 3 toggles every 2 cycles for 40 cycles, then settles at 0 → `gp_o[3]` stays 0; no pulses on any bit.
- Release with glitch: with `gp_o[1]`=1, drop bit 1 to 0 for 9 cycles, raise it 1 cycle, then hold 0 → qualification restarts after the glitch; `fall_o[1]` fires 11–14 cycles after the final drop.
- Simultaneous: bits 0–7 step 0x00→0xA5 in one cycle → `gp_o`=0xA5 with `rise_o`=0xA5 in the same single cycle.
- Reset mid-qualification: assert reset 6 cycles after a step on bit 2, release, hold the input at 1 → no pulse during reset; a full new qualification completes, then `rise_o[2]` fires. Re-run with the macro undefined → `rise_o`/`fall_o` are constant 0 and `gp_o` is identical.

Source files
------------

// File: rtl/gpi_debounce_pkg.sv
// gpi_debounce shared constants and types.
// Used by the debouncer top and its per-channel slice.
package gpi_debounce_pkg;

  localparam int DefaultTickCycles  = 50000;
  localparam int DefaultStableTicks = 10;
  localparam int MaxStableTicks     = 255;

  localparam int DebCntW = $clog2(MaxStableTicks + 1);

  typedef logic [DebCntW-1:0] deb_cnt_t;

endpackage

// File: rtl/gpi_debounce_chan.sv
// One debounced input channel: 2-flop sync, stability counter, level, edges.
// Edge registers exist only with GPI_DEBOUNCE_EDGE_EN defined.
module gpi_debounce_chan
  import gpi_debounce_pkg::*;
#(
  parameter int StableTicks = DefaultStableTicks
) (
  input  logic clk_sys_i,
  input  logic rst_sys_ni,
  input  logic tick_i,
  input  logic raw_i,
  output logic gp_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CntW =
    ($clog2(StableTicks + 1) < 1) ? 1 : $clog2(StableTicks + 1);
  localparam deb_cnt_t LastFull = deb_cnt_t'(StableTicks - 1);
  localparam logic [CntW-1:0] LastCnt = LastFull[CntW-1:0];

  logic [1:0]      sync_q;
  logic            sync;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;
  logic            gp_q;
  logic            gp_d;
  logic            match;
  logic            adv;
  logic            last;

  assign sync  = sync_q[1];
  assign match = (sync == gp_q);
  assign adv   = !match && tick_i;
  assign last  = (cnt_q == LastCnt);

  // Two-flop synchroniser for the asynchronous pin.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
    end
  end

  // Count ticks of continuous mismatch; accept the new level at the limit.
  always_comb begin
    cnt_d = cnt_q;
    gp_d  = gp_q;
    unique case (1'b1)
      match: cnt_d = '0;
      adv && last: begin
        gp_d  = sync;
        cnt_d = '0;
      end
      adv && !last: cnt_d = cnt_q + CntW'(1);
      default: ;
    endcase
  end

  // Counter and debounced level registers.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      cnt_q <= '0;
      gp_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      gp_q  <= gp_d;
    end
  end

  assign gp_o = gp_q;

`ifdef GPI_DEBOUNCE_EDGE_EN
  logic rise_q;
  logic fall_q;

  // Pulses line up with the cycle gp_o takes its new value.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= gp_d & ~gp_q;
      fall_q <= ~gp_d & gp_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`else
  assign rise_o = 1'b0;
  assign fall_o = 1'b0;
`endif

endmodule

// File: rtl/gpi_debounce.sv
// GPI debouncer top: shared sample prescaler plus Width channels.
// Optional edge pulses: define GPI_DEBOUNCE_EDGE_EN.
module gpi_debounce
  import gpi_debounce_pkg::*;
#(
  parameter int Width       = 8,
  parameter int TickCycles  = DefaultTickCycles,
  parameter int StableTicks = DefaultStableTicks
) (
  input  logic             clk_sys_i,
  input  logic             rst_sys_ni,
  input  logic [Width-1:0] gp_raw_i,
  output logic [Width-1:0] gp_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o,
  output logic             tick_o
);

  if (TickCycles < 1) begin : g_bad_tick
    $fatal(1, "gpi_debounce: TickCycles must be >= 1");
  end
  if (StableTicks < 1 || StableTicks > MaxStableTicks) begin : g_bad_st
    $fatal(1, "gpi_debounce: StableTicks must be 1..255");
  end

  localparam int PreW =
    (TickCycles > 1) ? $clog2(TickCycles) : 1;
  localparam logic [PreW-1:0] PreLast = PreW'(TickCycles - 1);

  logic [PreW-1:0] pre_q;
  logic            tick_q;

  // Free-running prescaler; tick is high the cycle after pre wraps.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
    end else if (pre_q == PreLast) begin
      pre_q  <= '0;
      tick_q <= 1'b1;
    end else begin
      pre_q  <= pre_q + PreW'(1);
      tick_q <= 1'b0;
    end
  end

  assign tick_o = tick_q;

  for (genvar i = 0; i < Width; i++) begin : g_chan
    gpi_debounce_chan #(
      .StableTicks(StableTicks)
    ) u_chan (
      .clk_sys_i (clk_sys_i),
      .rst_sys_ni(rst_sys_ni),
      .tick_i    (tick_q),
      .raw_i     (gp_raw_i[i]),
      .gp_o      (gp_o[i]),
      .rise_o    (rise_o[i]),
      .fall_o    (fall_o[i])
    );
  end

endmodule

// File: tb/tb_gpi_debounce.sv
// Self-checking bench for gpi_debounce (TickCycles=4, StableTicks=3).
// Directed scenarios plus random toggling against a behavioural model.
module tb_gpi_debounce;

  localparam int W = 8;
  localparam int T = 4;
  localparam int S = 3;
`ifdef GPI_DEBOUNCE_EDGE_EN
  localparam bit EdgeEn = 1'b1;
`else
  localparam bit EdgeEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] raw = '0;
  logic [W-1:0] gp;
  logic [W-1:0] rise;
  logic [W-1:0] fall;
  logic         tick;

  gpi_debounce #(
    .Width(W), .TickCycles(T), .StableTicks(S)
  ) dut (
    .clk_sys_i (clk),
    .rst_sys_ni(rst_n),
    .gp_raw_i  (raw),
    .gp_o      (gp),
    .rise_o    (rise),
    .fall_o    (fall),
    .tick_o    (tick)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state, in terms of observable behaviour:
  // cycles since release, delayed pin view, ticks seen in a mismatch run.
  int           n;
  logic [W-1:0] m_gp, m_rise, m_fall, m_view, m_prev;
  logic         m_tick;
  int           run_ticks [W];

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    n = 0;
    m_gp = '0; m_rise = '0; m_fall = '0;
    m_view = '0; m_prev = '0; m_tick = 1'b0;
    for (int i = 0; i < W; i++) run_ticks[i] = 0;
  endtask

  // One clock edge: a level is accepted once S sample ticks have
  // been seen while the delayed pin continuously differs from it.
  task automatic model_edge(input logic [W-1:0] v);
    n++;
    m_rise = '0;
    m_fall = '0;
    for (int i = 0; i < W; i++) begin
      if (m_view[i] == m_gp[i]) begin
        run_ticks[i] = 0;
      end else if (m_tick) begin
        run_ticks[i] = run_ticks[i] + 1;
        if (run_ticks[i] == S) begin
          m_gp[i] = m_view[i];
          if (m_view[i]) m_rise[i] = 1'b1;
          else m_fall[i] = 1'b1;
          run_ticks[i] = 0;
        end
      end
    end
    m_view = m_prev;
    m_prev = v;
    m_tick = (n % T == 0);
  endtask

  task automatic cyc(input logic [W-1:0] v);
    raw = v;
    @(posedge clk);
    #1;
    if (!rst_n) model_reset();
    else model_edge(v);
    check("gp", 32'(gp), 32'(m_gp));
    check("rise", 32'(rise), EdgeEn ? 32'(m_rise) : 32'h0);
    check("fall", 32'(fall), EdgeEn ? 32'(m_fall) : 32'h0);
    check("tick", 32'(tick), 32'(m_tick));
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    #1;
    check("rst_gp", 32'(gp), 32'h0);
    check("rst_rise", 32'(rise), 32'h0);
    check("rst_fall", 32'(fall), 32'h0);
    model_reset();
    for (int k = 0; k < cycles; k++) cyc(raw);
    rst_n = 1'b1;
  endtask

  int lat;
  bit got;

  initial begin
    model_reset();
    raw = '0;
    @(posedge clk);
    #1;
    do_reset(3);

    // idle
    for (int k = 0; k < 100; k++) cyc(8'h00);

    // clean press on bit 0
    got = 0; lat = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc(8'h01);
      if (!got && gp[0]) begin
        got = 1; lat = k;
        check("press_rise0", 32'(rise[0]), 32'(EdgeEn));
      end
    end
    check("press_lat", 32'(got && lat >= 11 && lat <= 14), 32'h1);

    // bounce on bit 3
    for (int k = 0; k < 40; k++)
      cyc(((k / 2) % 2 == 1) ? 8'h09 : 8'h01);
    for (int k = 0; k < 20; k++) cyc(8'h01);
    check("bounce_gp3", 32'(gp[3]), 32'h0);

    // release with glitch on bit 1
    for (int k = 0; k < 20; k++) cyc(8'h03);
    check("glitch_pre_gp1", 32'(gp[1]), 32'h1);
    for (int k = 0; k < 9; k++) cyc(8'h01);
    cyc(8'h03);
    check("glitch_hold_gp1", 32'(gp[1]), 32'h1);
    got = 0; lat = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc(8'h01);
      if (!got && !gp[1]) begin
        got = 1; lat = k;
        check("glitch_fall1", 32'(fall[1]), 32'(EdgeEn));
      end
    end
    check("glitch_lat", 32'(got && lat >= 11 && lat <= 14), 32'h1);

    // simultaneous step 0x00 -> 0xA5
    do_reset(2);
    for (int k = 0; k < 3; k++) cyc(8'h00);
    got = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc(8'hA5);
      if (!got && gp != 0) begin
        got = 1;
        check("simul_gp", 32'(gp), 32'hA5);
        check("simul_rise", 32'(rise), EdgeEn ? 32'hA5 : 32'h0);
      end
    end
    check("simul_seen", 32'(got), 32'h1);

    // reset mid-qualification on bit 2
    do_reset(2);
    for (int k = 0; k < 5; k++) cyc(8'h00);
    for (int k = 0; k < 6; k++) cyc(8'h04);
    do_reset(3);
    got = 0; lat = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc(8'h04);
      if (!got && gp[2]) begin
        got = 1; lat = k;
        check("rstmid_rise2", 32'(rise[2]), 32'(EdgeEn));
      end
    end
    check("rstmid_lat", 32'(got && lat >= 11 && lat <= 14), 32'h1);

    // random toggling with one random reset
    for (int k = 0; k < 1500; k++) begin
      logic [W-1:0] v;
      v = raw;
      for (int i = 0; i < W; i++)
        if ($urandom_range(0, 11) == 0) v[i] = ~v[i];
      if (k == 700) do_reset(int'($urandom_range(1, 4)));
      cyc(v);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
